// File: rtl/data_mem_dma.sv
// Data-memory bus master: block copy (src->dst) or block fill (constant->dst) of up to 2^data_mem_length words.
// Optional macro DATA_MEM_DMA_CHECKSUM_EN adds a running modulo sum of all written words.
module data_mem_dma #(
    parameter int data_mem_length = 8,
    parameter int data_mem_width  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       mode,
    input  logic [data_mem_length-1:0] src,
    input  logic [data_mem_length-1:0] dst,
    input  logic [data_mem_length:0]   len,
    input  logic [data_mem_width-1:0]  fill_val,
    output logic [data_mem_length-1:0] mem_addr,
    output logic                       mem_wr,
    output logic [data_mem_width-1:0]  mem_wdata,
    input  logic [data_mem_width-1:0]  mem_rdata,
    output logic                       busy,
    output logic                       done,
`ifdef DATA_MEM_DMA_CHECKSUM_EN
    output logic [data_mem_width-1:0]  checksum,
`endif
    output logic [data_mem_length:0]   words_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [data_mem_length:0] LAST_WORD = 1;

    logic [1:0]                 state;
    logic [data_mem_length-1:0] src_ptr;
    logic [data_mem_length-1:0] dst_ptr;
    logic [data_mem_length-1:0] last_addr;
    logic [data_mem_length:0]   remaining;
    logic                       mode_q;
    logic [data_mem_width-1:0]  fill_q;
    logic [data_mem_width-1:0]  data_buf;

    // Outputs decode from registered state only; address parks on the last driven value when idle.
    always_comb begin
        mem_addr  = last_addr;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_RD: mem_addr = src_ptr;
            S_WR: begin
                mem_addr  = dst_ptr;
                mem_wr    = 1'b1;
                mem_wdata = mode_q ? fill_q : data_buf;
            end
            default: ;
        endcase
    end

    assign busy = (state == S_RD) || (state == S_WR);
    assign done = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            last_addr  <= '0;
            remaining  <= '0;
            mode_q     <= 1'b0;
            fill_q     <= '0;
            data_buf   <= '0;
            words_done <= '0;
`ifdef DATA_MEM_DMA_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr    <= src;
                        dst_ptr    <= dst;
                        remaining  <= len;
                        mode_q     <= mode;
                        fill_q     <= fill_val;
                        words_done <= '0;
`ifdef DATA_MEM_DMA_CHECKSUM_EN
                        checksum   <= '0;
`endif
                        if (len == '0)
                            state <= S_FIN;
                        else
                            state <= mode ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    last_addr <= src_ptr;
                    data_buf  <= mem_rdata;
                    src_ptr   <= src_ptr + 1'b1;
                    state     <= abort ? S_FIN : S_WR;
                end
                S_WR: begin
                    // The write on this edge always lands and is counted, even when aborting.
                    last_addr  <= dst_ptr;
                    dst_ptr    <= dst_ptr + 1'b1;
                    remaining  <= remaining - 1'b1;
                    words_done <= words_done + 1'b1;
`ifdef DATA_MEM_DMA_CHECKSUM_EN
                    checksum   <= checksum + mem_wdata;
`endif
                    if (abort || remaining == LAST_WORD)
                        state <= S_FIN;
                    else
                        state <= mode_q ? S_WR : S_RD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_dma.sv
// Randomized bench for data_mem_dma: async-read memory stub plus a word-level transfer model.
module tb_data_mem_dma;

    localparam int L     = 8;
    localparam int W     = 8;
    localparam int DEPTH = 1 << L;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, abort, mode;
    logic [L-1:0] src, dst;
    logic [L:0]   len;
    logic [W-1:0] fill_val;
    logic [L-1:0] mem_addr;
    logic         mem_wr;
    logic [W-1:0] mem_wdata, mem_rdata;
    logic         busy, done;
    logic [L:0]   words_done;
`ifdef DATA_MEM_DMA_CHECKSUM_EN
    logic [W-1:0] checksum;
`endif

    always #5 clk = ~clk;

    data_mem_dma #(.data_mem_length(L), .data_mem_width(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .src(src), .dst(dst), .len(len), .fill_val(fill_val),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done),
`ifdef DATA_MEM_DMA_CHECKSUM_EN
        .checksum(checksum),
`endif
        .words_done(words_done)
    );

    logic [W-1:0] mem     [DEPTH];
    logic [W-1:0] ref_mem [DEPTH];
    int wr_total = 0;
    int n_chk = 0;
    int n_err = 0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr] = mem_wdata;
            wr_total = wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer; abort_at>0 raises abort during that WR cycle.
    task automatic xfer(input bit md, input int s, input int d, input int n,
                        input logic [W-1:0] fv, input int abort_at);
        int k, exp_lat, exp_sum, w0, cyc, busy_cnt, wr_seen, rd_seen, diffs;
        k = (abort_at > 0 && abort_at < n) ? abort_at : n;
        exp_sum = 0;
        for (int i = 0; i < k; i++)
            ref_mem[(d + i) % DEPTH] = md ? fv : ref_mem[(s + i) % DEPTH];
        for (int i = 0; i < k; i++)
            exp_sum = (exp_sum + int'(ref_mem[(d + i) % DEPTH])) % (1 << W);
        exp_lat = md ? k + 1 : 2 * k + 1;
        w0 = wr_total;

        @(negedge clk);
        mode = md; src = L'(s); dst = L'(d); len = (L+1)'(n); fill_val = fv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1; busy_cnt = 0; wr_seen = 0; rd_seen = 0;
        while (!done && cyc < 1200) begin
            if (busy) busy_cnt++;
            if (mem_wr) begin
                chk("wr_addr", 32'(mem_addr), 32'((d + wr_seen) % DEPTH));
                chk("wr_data", 32'(mem_wdata), 32'(ref_mem[(d + wr_seen) % DEPTH]));
                wr_seen++;
                abort = (wr_seen == abort_at);
            end else if (busy) begin
                chk("rd_addr", 32'(mem_addr), 32'((s + rd_seen) % DEPTH));
                rd_seen++;
                abort = 1'b0;
            end else begin
                abort = 1'b0;
            end
            // Garbage on the request inputs and stray start pulses must not disturb a running transfer.
            start = busy && ($urandom_range(0, 3) == 0);
            src = L'($urandom); dst = L'($urandom); len = (L+1)'($urandom);
            mode = 1'($urandom); fill_val = W'($urandom);
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0; start = 1'b0;
        chk("done_latency", 32'(cyc), 32'(exp_lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        chk("words_done", 32'(words_done), 32'(k));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("writes", 32'(wr_total - w0), 32'(k));
`ifdef DATA_MEM_DMA_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(exp_sum));
`endif
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 32'd0);
    endtask

    initial begin
        int w0, done_cnt;
        logic [W-1:0] guard;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
        src = '0; dst = '0; len = '0; fill_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = W'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_words", 32'(words_done), 32'd0);
`ifdef DATA_MEM_DMA_CHECKSUM_EN
        chk("rst_checksum", 32'(checksum), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed copy
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
        for (int i = 16; i < 20; i++) ref_mem[i] = mem[i];
        xfer(1'b0, 'h10, 'h40, 4, 8'h00, 0);
        chk("copy_word3", 32'(mem[8'h43]), 32'hD4);

        // Directed fill; word past the end untouched
        guard = mem[8'h23];
        xfer(1'b1, 'h00, 'h20, 3, 8'h5A, 0);
        chk("fill_guard", 32'(mem[8'h23]), 32'(guard));
`ifdef DATA_MEM_DMA_CHECKSUM_EN
        chk("fill_checksum", 32'(checksum), 32'h0E);
`endif

        // Address wrap on source
        xfer(1'b0, 'hFE, 'h7E, 4, 8'h00, 0);
        // Zero length
        xfer(1'b0, 'h33, 'h44, 0, 8'h00, 0);
        // Abort in the third WR cycle, with start held alongside abort in IDLE
        xfer(1'b0, 'h30, 'h90, 8, 8'h00, 3);
        abort = 1'b1;
        xfer(1'b1, 'h00, 'hC0, 2, 8'h77, 0);

        // Abort while idle has no effect
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_done", 32'(done), 32'd0);

        // Randomized transfers, including overlapping copies and a full-depth one
        for (int t = 0; t < 16; t++) begin
            int n;
            n = (t == 0) ? DEPTH : $urandom_range(0, 20);
            xfer(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, DEPTH - 1), n, W'($urandom), 0);
        end

        // Reset in the middle of a fill
        @(negedge clk);
        mode = 1'b1; dst = 8'h50; len = 9'd10; fill_val = 8'h33; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_wr", 32'(mem_wr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_words", 32'(words_done), 32'd0);
        w0 = wr_total;
        done_cnt = 0;
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("midrst_no_writes", 32'(wr_total - w0), 32'd0);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_dma.md
Name: data_mem_dma

Overview:
- Bus master for the data memory. It drives the memory's address, write-enable (wrDm) and write-data inputs and samples its asynchronous read output.
- Performs block copy (src→dst) or block fill (constant→dst) over N words without CPU involvement.
- Sits beside the core and shares the data-memory port; the core arbitrates via busy.

Parameters:
- data_mem_length, 8, address width; memory depth = 2^data_mem_length words
- data_mem_width, 8, data word width in bits

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- start  in  1  request pulse; sampled only in IDLE
- abort  in  1  terminate transfer; takes effect on next edge
- mode  in  1  0 = copy, 1 = fill
- src  in  data_mem_length  copy source base address
- dst  in  data_mem_length  destination base address
- len  in  data_mem_length+1  word count, 0..2^data_mem_length
- fill_val  in  data_mem_width  fill constant
- mem_addr  out  data_mem_length  to memory addr
- mem_wr  out  1  to memory wrDm
- mem_wdata  out  data_mem_width  to memory in
- mem_rdata  in  data_mem_width  from memory out (combinational)
- busy  out  1  high in RD/WR states
- done  out  1  one-cycle pulse at completion or abort
- words_done  out  data_mem_length+1  words written in last or current transfer

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; mem_addr=0, mem_wr=0, mem_wdata=0, busy=0, done=0, words_done=0; internal pointers, counter and buffer cleared. Reset mid-transfer aborts immediately with no done pulse.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - start=1 latches src, dst, len, mode and fill_val; clears words_done.
  - len=0 → FIN (no memory write).
  - Otherwise mode=0 → RD; mode=1 → WR.
- RD: mem_addr=src_ptr, mem_wr=0. At edge, buf←mem_rdata and src_ptr+1; next state WR.
- WR:
  - mem_addr=dst_ptr, mem_wr=1, mem_wdata=buf (copy) or fill_val (fill).
  - At edge: dst_ptr+1, remaining−1, words_done+1.
  - If remaining was 1 → FIN; else next state RD (copy) or WR (fill).
- FIN: done=1 for exactly one cycle, busy=0; next state IDLE.
- mem_wr is decoded only from the registered state (state==WR), so it is glitch-free. mem_wr=0 in every other state.
- mem_addr is registered-state-decoded. In IDLE and FIN it holds the last driven value.
- Throughput: copy takes 2 cycles/word; fill takes 1 cycle/word. From the start edge to the done pulse is 2N+1 cycles (copy) or N+1 cycles (fill).
- Pointer arithmetic is modulo 2^data_mem_length. Addresses wrap 0xFF→0x00 at default width.
- Overlap: copy is strictly ascending. If dst lies in (src, src+len), already-copied words are re-read; this is defined behaviour and is not corrected.
- start while busy or in FIN is ignored.
- abort=1 in RD or WR: the next edge goes to FIN (done pulses). A write in progress in that WR cycle completes and is counted. abort in IDLE has no effect.
- start and abort both high in IDLE: start wins.

Optional Feature:
- Macro: DATA_MEM_DMA_CHECKSUM_EN.
- When defined:
  - Adds output checksum [data_mem_width-1:0].
  - Cleared on accepted start.
  - On every WR edge it adds the written word modulo 2^data_mem_width.
  - Holds its value after FIN until the next start. Reset value is 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Copy: mem[0x10..0x13]={0xA1,0xB2,0xC3,0xD4}, start mode=0 src=0x10 dst=0x40 len=4 → mem[0x40..0x43] equals the source; done pulses at cycle 9 after start; words_done=4; busy high for 8 cycles.
- Fill: start mode=1 dst=0x20 len=3 fill_val=0x5A → mem[0x20..0x22]=0x5A and mem[0x23] unchanged; done at cycle 4; with CHECKSUM_EN, checksum=0x0E.
- Wrap: copy src=0xFE dst=0x7E len=4 → reads 0xFE, 0xFF, 0x00, 0x01; writes 0x7E..0x81.
- len=0: start → no mem_wr asserted; done pulses at next cycle; words_done=0.
- Abort: copy len=8, abort asserted in the 3rd WR cycle → exactly 3 words written; done pulses once; words_done=3; start during busy ignored.
- Reset mid-fill: rst_n=0 during WR → next cycle mem_wr=0, busy=0, done=0, words_done=0; no further writes.
